// File: rtl/fifo36k_ctrl_pkg.sv
// rtl/fifo36k_ctrl_pkg.sv - shared types and sizing helpers for the FIFO36K write-side control
package fifo36k_ctrl_pkg;

    // Occupancy counter width; holds up to 4096 entries
    localparam int LEVEL_W = 13;

    // Width of producer indices (up to 8 producers)
    localparam int GRANT_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // FIFO36K depth for a given write width in synchronous mode
    function automatic int fifo_depth(input int width);
        case (width)
            9:       return 4096;
            18:      return 2048;
            default: return 1024;
        endcase
    endfunction

endpackage

// File: rtl/fifo36k_wr_arbiter_if.sv
// rtl/fifo36k_wr_arbiter_if.sv - producer handshake and FIFO write-port bundle
interface fifo36k_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 36
);

    // Producer side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    // FIFO side
    logic                          fifo_rd_en;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;

    // Arbiter end of the bundle
    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  fifo_rd_en,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );

    // Producers / FIFO model end of the bundle
    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output fifo_rd_en,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

endinterface

// File: rtl/fifo36k_rr_pick.sv
// rtl/fifo36k_rr_pick.sv - circular first-one search starting after the last served index
module fifo36k_rr_pick
    import fifo36k_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = GRANT_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Two linear passes: indices above last_i first, then wrap to 0..last_i
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_o && req_i[i] && (i > int'(last_i))) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_o && req_i[i] && (i <= int'(last_i))) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo36k_wr_arbiter.sv
// rtl/fifo36k_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO36K write port
module fifo36k_wr_arbiter
    import fifo36k_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 36,
    parameter int MAX_BURST  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo36k_wr_arbiter_if.slave  bus,
    output logic [GRANT_W-1:0]   grant_id_o,
    output logic                 busy_o,
    output logic [LEVEL_W-1:0]   level_o,
    output logic                 wr_err_o
);

    localparam logic [LEVEL_W-1:0] DEPTH = LEVEL_W'(fifo_depth(DATA_WIDTH));
    localparam logic [7:0]         MAX_B = 8'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [GRANT_W-1:0]    grant_q, grant_d;
    logic [GRANT_W-1:0]    last_q, last_d;
    logic [7:0]            beat_q, beat_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_err_q, wr_err_d;

    logic                  pick_found;
    logic [GRANT_W-1:0]    pick_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    ready;
    logic                  can_accept;
    logic                  beat;
    logic                  rd_dec;

    fifo36k_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Our own count includes the beat still sitting in the output register,
    // so this is the only full check needed; FIFO FULL lags and is not used here.
    assign can_accept = (level_q < DEPTH);
    assign beat       = (state_q == BURST) && sel_valid && can_accept;
    assign rd_dec     = bus.fifo_rd_en && (level_q != '0);

    // Select the granted producer's valid/last/data
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the granted producer sees ready, and only while there is room
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = (state_q == BURST) && (grant_q == GRANT_W'(i)) && can_accept;
        end
    end

    // Arbitration FSM: grant on IDLE, leave BURST on last, burst limit or yield
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    beat_d = beat_q + 8'd1;
                    if (sel_last || ((beat_q + 8'd1) == MAX_B)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (!sel_valid) begin
                    // A stall on a full FIFO keeps the grant; only a dropped valid releases it
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write register, occupancy and sticky overflow error next-state
    always_comb begin
        wr_en_d   = beat;
        wr_data_d = beat ? sel_data : wr_data_q;
        level_d   = level_q + LEVEL_W'(beat) - LEVEL_W'(rd_dec);
        wr_err_d  = wr_err_q | (wr_en_q & bus.fifo_full);
    end

    // State and datapath registers; reset drops any beat held in the write register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GRANT_W'(NUM_REQ - 1);
            beat_q    <= '0;
            level_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            level_q   <= level_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign grant_id_o       = grant_q;
    assign busy_o           = (state_q == BURST);
    assign level_o          = level_q;
    assign wr_err_o         = wr_err_q;

endmodule

// File: tb/tb_fifo36k_wr_arbiter.sv
// tb/tb_fifo36k_wr_arbiter.sv - directed self-checking bench for the FIFO36K write arbiter
module tb_fifo36k_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 36;
    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  grant_id;
    logic        busy;
    logic [12:0] level;
    logic        wr_err;

    fifo36k_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo36k_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .grant_id_o (grant_id),
        .busy_o     (busy),
        .level_o    (level),
        .wr_err_o   (wr_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int rem     [NR];
    int last_at [NR];
    int sent    [NR];

    logic [NR-1:0] acc = '0;
    logic [DW-1:0] wr_q [$];
    int            grant_seq [$];
    int            len_q [$];
    int            gap_q [$];
    logic          busy_prev = 1'b0;
    int            cur_len = 0;
    int            idle_run = 0;
    int            nrd = 0;
    logic          force_full = 1'b0;

    function automatic logic [DW-1:0] dval(input int p, input int n);
        return {4'(p + 1), 32'(n)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
        n_vec++;
        assert (obsv === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obsv, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = (rem[i] != 0);
            bus.req_last[i]  = (last_at[i] != 0) && ((sent[i] + 1) == last_at[i]);
            bus.req_data[i*DW +: DW] = dval(i, sent[i]);
        end
        bus.fifo_full = force_full || ((wr_q.size() - nrd) >= 1024);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.fifo_rd_en && (wr_q.size() > nrd)) nrd++;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    sent[i]++;
                    if (rem[i] > 0) rem[i]--;
                end
            end
            drive();
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0;
            last_at[i] = 0;
            sent[i] = 0;
        end
        bus.fifo_rd_en = 1'b0;
        force_full = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_q.delete();
        grant_seq.delete();
        len_q.delete();
        gap_q.delete();
        nrd = 0;
        drive();
        #1;
    endtask

    // Observe accepted beats, FIFO writes and burst boundaries away from the active edge
    always @(negedge clk) begin
        acc = bus.req_valid & bus.req_ready;
        if (bus.fifo_wr_en) wr_q.push_back(bus.fifo_wr_data);
        if (busy && !busy_prev) begin
            grant_seq.push_back(int'(grant_id));
            gap_q.push_back(idle_run);
            cur_len = 0;
        end
        if (!busy && busy_prev) len_q.push_back(cur_len);
        if (busy) cur_len += $countones(acc);
        idle_run = busy ? 0 : idle_run + 1;
        busy_prev = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fifo_rd_en = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0;
            last_at[i] = 0;
            sent[i] = 0;
        end
        drive();
        @(posedge clk);
        #2;

        // Reset state
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_wr_data", bus.fifo_wr_data, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_err", wr_err, 0);

        // Single producer: 5 beats on producer 2, LAST on beat 5
        do_reset();
        rem[2] = 5;
        last_at[2] = 5;
        drive();
        step(1);
        chk("t1_ready_arb", bus.req_ready, 4'b0100);
        chk("t1_wr_en_arb", bus.fifo_wr_en, 0);
        chk("t1_grant", grant_id, 2);
        step(1);
        chk("t1_wr_en_first", bus.fifo_wr_en, 1);
        chk("t1_data_first", bus.fifo_wr_data, dval(2, 0));
        step(10);
        chk("t1_writes", wr_q.size(), 5);
        for (int k = 0; k < 5; k++) chk("t1_order", wr_q[k], dval(2, k));
        chk("t1_level", level, 5);
        chk("t1_grant_end", grant_id, 2);
        chk("t1_busy_end", busy, 0);
        chk("t1_len", len_q[0], 5);
        chk("t1_wr_err", wr_err, 0);

        // Round-robin with all producers continuously valid
        do_reset();
        for (int i = 0; i < NR; i++) rem[i] = -1;
        drive();
        step(48);
        for (int k = 0; k < 5; k++) chk("t2_grant_seq", grant_seq[k], k % NR);
        for (int k = 0; k < 4; k++) chk("t2_burst_len", len_q[k], MB);
        for (int k = 1; k < 5; k++) chk("t2_bubble", gap_q[k], 1);
        chk("t2_data_p1_first", wr_q[8], dval(1, 0));
        chk("t2_data_p3_last", wr_q[31], dval(3, 7));

        // Full boundary: producer 0 streams 1030 beats into a 1024-deep FIFO, no reads
        do_reset();
        rem[0] = 1030;
        drive();
        step(1200);
        chk("t3_writes", wr_q.size(), 1024);
        chk("t3_sent", sent[0], 1024);
        chk("t3_ready_full", bus.req_ready, 0);
        chk("t3_level_full", level, 1024);
        chk("t3_busy_held", busy, 1);
        chk("t3_grant_held", grant_id, 0);
        chk("t3_wr_err", wr_err, 0);
        bus.fifo_rd_en = 1'b1;
        step(1);
        bus.fifo_rd_en = 1'b0;
        chk("t3_level_after_rd", level, 1023);
        chk("t3_ready_after_rd", bus.req_ready, 4'b0001);
        step(1);
        chk("t3_level_refill", level, 1024);
        chk("t3_ready_refull", bus.req_ready, 0);
        step(5);
        chk("t3_one_more_write", wr_q.size(), 1025);
        chk("t3_one_more_sent", sent[0], 1025);

        // Simultaneous read and beat at the full boundary
        bus.fifo_rd_en = 1'b1;
        step(1);
        chk("t3s_level_rd", level, 1023);
        step(1);
        chk("t3s_level_rd_and_beat", level, 1023);
        bus.fifo_rd_en = 1'b0;
        step(1);
        chk("t3s_level_beat", level, 1024);
        step(5);
        chk("t3s_writes", wr_q.size(), 1027);
        chk("t3s_wr_err", wr_err, 0);

        // Yield: producer 1 drops valid after 3 beats, producer 2 waits
        do_reset();
        rem[1] = 3;
        rem[2] = 4;
        drive();
        step(4);
        chk("t4_busy_p1", busy, 1);
        chk("t4_sent_p1", sent[1], 3);
        step(1);
        chk("t4_released", busy, 0);
        chk("t4_last_grant", grant_id, 1);
        step(15);
        chk("t4_grant0", grant_seq[0], 1);
        chk("t4_grant1", grant_seq[1], 2);
        chk("t4_len_p1", len_q[0], 3);
        chk("t4_len_p2", len_q[1], 4);
        chk("t4_bubble", gap_q[1], 1);
        chk("t4_data_p2", wr_q[3], dval(2, 0));

        // WR_ERR: a write while FULL is forced high sets the sticky error one cycle later
        do_reset();
        force_full = 1'b1;
        rem[3] = 1;
        last_at[3] = 1;
        drive();
        step(2);
        chk("t6_wr_en", bus.fifo_wr_en, 1);
        chk("t6_err_not_yet", wr_err, 0);
        step(1);
        chk("t6_err_set", wr_err, 1);
        step(3);
        chk("t6_err_sticky", wr_err, 1);

        // Read while empty, then reset in the middle of a burst
        do_reset();
        bus.fifo_rd_en = 1'b1;
        step(1);
        bus.fifo_rd_en = 1'b0;
        chk("t5_rd_empty", level, 0);
        rem[0] = -1;
        rem[1] = -1;
        drive();
        step(4);
        chk("t5_level_pre", level, 3);
        chk("t5_wr_en_pre", bus.fifo_wr_en, 1);
        chk("t5_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_grant", grant_id, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", bus.req_ready, 0);
        chk("t5_rst_wr_en", bus.fifo_wr_en, 0);
        chk("t5_rst_wr_data", bus.fifo_wr_data, 0);
        chk("t5_rst_level", level, 0);
        chk("t5_rst_wr_err", wr_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) sent[i] = 0;
        drive();
        #1;
        step(1);
        chk("t5_regrant_p0", grant_id, 0);
        chk("t5_regrant_busy", busy, 1);
        chk("t5_level_restart", level, 0);
        step(1);
        chk("t5_level_first", level, 1);
        chk("t5_data_first", bus.fifo_wr_data, dval(0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
